// File: rtl/ahb_pkg.sv
// Shared AHB-Lite code points and the SRAM slave state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for a transfer of size i_size at byte offset i_addr.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_strb_c
);

  always_comb begin
    o_strb_c = 4'b0000;
    case (i_size)
      HSIZE_BYTE: o_strb_c = 4'b0001 << i_addr;
      HSIZE_HALF: o_strb_c = i_addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: o_strb_c = 4'b1111;
      default:    o_strb_c = 4'b0000;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: configurable wait states, two-cycle ERROR for bad transfers,
// byte-lane writes and a combinational read path from the word array.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned LP_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LP_SPAN   = 32'(DEPTH * 4);
  localparam logic [2:0]  LP_CNT_LD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  slave_state_e          r_state;
  slave_state_e          w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;
  logic [LP_IDX_W-1:0]   r_idx;
  logic [1:0]            r_lane;
  logic [2:0]            r_size;
  logic                  r_write;
  logic [31:0]           r_mem [DEPTH];

  logic [31:0] w_off;
  logic        w_accept;
  logic        w_err;
  logic        w_load;
  logic [3:0]  w_strb;

  // Offset wraps for addresses below the base, so one unsigned compare covers both ends.
  assign w_off    = haddr - BASE_ADDR;
  assign w_accept = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign w_err    = (hsize > HSIZE_WORD)
                 || ((hsize == HSIZE_HALF) && haddr[0])
                 || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))
                 || (w_off >= LP_SPAN);

  ahb_byte_strobe u_strobe (
    .i_size   (r_size),
    .i_addr   (r_lane),
    .o_strb_c (w_strb)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    case (r_state)
      ST_IDLE: w_load = w_accept;
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (r_cnt == 3'd0) w_state_nxt = ST_DATA;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      ST_DATA: begin
        w_state_nxt = ST_IDLE;
        w_load      = w_accept;
      end
      ST_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp       = HRESP_ERROR;
        w_state_nxt = ST_IDLE;
        w_load      = w_accept;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load) begin
      w_cnt_nxt = 3'd0;
      if (w_err)                 w_state_nxt = ST_ERR1;
      else if (WAIT_STATES == 0) w_state_nxt = ST_DATA;
      else begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = LP_CNT_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= 3'd0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_idx   <= w_off[LP_IDX_W+1:2];
        r_lane  <= haddr[1:0];
        r_size  <= hsize;
        r_write <= hwrite;
      end
    end
  end

  // Array is never reset; a write commits only on the edge that closes ST_DATA.
  always_ff @(posedge clk) begin
    if ((r_state == ST_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = ((r_state == ST_DATA) && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench: slave A (1 wait state) and slave B (0 wait states) on one pipelined bus.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    logic        sel;
    logic        en;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        sel;
    logic        err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        bus_hready;
  logic        hro_a, hro_b;
  logic        hresp_a, hresp_b;
  logic [31:0] hrd_a, hrd_b;

  op_t         q_ops[$];
  exp_t        q_sb[$];
  logic [31:0] mdl_mem [2][256];
  int          n_checks = 0;
  int          n_errors = 0;

  assign bus_hready = hro_a & hro_b;

  ahb_sram_slave u_dut_a (
    .clk(clk), .reset(rst_n), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(bus_hready),
    .hreadyout(hro_a), .hresp(hresp_a), .hrdata(hrd_a)
  );

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(rst_n), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(bus_hready),
    .hreadyout(hro_b), .hresp(hresp_b), .hrdata(hrd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    off = addr - 32'h0000_1000;
    return (size > 3'd2) || ((size == 3'd1) && addr[0]) ||
           ((size == 3'd2) && (addr[1:0] != 2'b00)) || (off >= 32'd1024);
  endfunction

  function automatic bit lane_en(input logic [2:0] size, input logic [1:0] a, input int b);
    case (size)
      3'd0:    return b == int'(a);
      3'd1:    return (b / 2) == int'(a[1]);
      3'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic bus_idle();
    hsel_a = 1'b0;
    hsel_b = 1'b0;
    haddr  = 32'h0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = HSIZE_WORD;
  endtask

  // Present an address phase and push what its data phase must look like.
  task automatic drive_ap(input op_t o);
    exp_t        e;
    int unsigned idx;
    hsel_a = o.en && !o.sel;
    hsel_b = o.en && o.sel;
    haddr  = o.addr;
    htrans = o.trans;
    hwrite = o.write;
    hsize  = o.size;
    e.sel = o.sel; e.err = 1'b0; e.waits = 0; e.rdata = 32'h0;
    if (o.en && o.trans[1]) begin
      e.err = is_err(o.addr, o.size);
      if (e.err) e.waits = 1;
      else begin
        e.waits = o.sel ? 0 : 1;
        idx = (o.addr - 32'h0000_1000) >> 2;
        if (o.write) begin
          for (int b = 0; b < 4; b++)
            if (lane_en(o.size, o.addr[1:0], b)) mdl_mem[o.sel][idx][8*b +: 8] = o.wdata[8*b +: 8];
        end else e.rdata = mdl_mem[o.sel][idx];
      end
    end
    q_sb.push_back(e);
  endtask

  task automatic push_op(input logic sel, input logic en, input logic [1:0] tr,
                         input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] d);
    op_t o;
    o.sel = sel; o.en = en; o.trans = tr; o.addr = a; o.write = w; o.size = sz; o.wdata = d;
    q_ops.push_back(o);
  endtask

  task automatic wr(input logic sel, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    push_op(sel, 1'b1, HTRANS_NONSEQ, a, 1'b1, sz, d);
  endtask

  task automatic rd(input logic sel, input logic [31:0] a, input logic [2:0] sz);
    push_op(sel, 1'b1, HTRANS_NONSEQ, a, 1'b0, sz, 32'h0);
  endtask

  // Pipelined bus engine: drive/sample at negedge, hwdata one cycle later after the edge.
  task automatic run_ops();
    int   budget;
    logic rdy, dp_v, ap_v;
    int   waits;
    op_t  ap;
    exp_t e;
    budget = 500; dp_v = 1'b0; ap_v = 1'b0; waits = 0;
    ap = '{default: '0};
    while ((q_ops.size() != 0 || dp_v) && budget > 0) begin
      @(negedge clk);
      budget--;
      rdy = bus_hready;
      if (dp_v) begin
        e = q_sb[0];
        if (!rdy) begin
          waits++;
          check("wait_resp", 32'(e.sel ? hresp_b : hresp_a), 32'(e.err));
        end else begin
          e = q_sb.pop_front();
          check("waits", 32'(waits), 32'(e.waits));
          check("hresp", 32'(e.sel ? hresp_b : hresp_a), 32'(e.err));
          check("hrdata", e.sel ? hrd_b : hrd_a, e.rdata);
        end
      end
      if (rdy) begin
        if (q_ops.size() != 0) begin
          ap = q_ops.pop_front();
          drive_ap(ap);
          ap_v = 1'b1;
        end else begin
          bus_idle();
          ap_v = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        dp_v   = ap_v;
        waits  = 0;
        hwdata = (ap_v && ap.write) ? ap.wdata : 32'h0;
      end
    end
    check("drained", 32'(q_ops.size()) + 32'(dp_v), 32'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    #12;
    check("rst_ready_a", 32'(hro_a), 32'h1);
    check("rst_resp_a", 32'(hresp_a), 32'h0);
    check("rst_rdata_a", hrd_a, 32'h0);
    check("rst_ready_b", 32'(hro_b), 32'h1);
    check("rst_rdata_b", hrd_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Slave A: word, byte and halfword traffic plus range boundaries.
    wr(0, 32'h1000, HSIZE_WORD, 32'hDEADBEEF);
    rd(0, 32'h1000, HSIZE_WORD);
    wr(0, 32'h1000, HSIZE_WORD, 32'h11223344);
    wr(0, 32'h1002, HSIZE_BYTE, 32'h00AB0000);
    rd(0, 32'h1000, HSIZE_WORD);
    wr(0, 32'h1004, HSIZE_WORD, 32'h01020304);
    wr(0, 32'h1006, HSIZE_HALF, 32'hBEEF0000);
    rd(0, 32'h1004, HSIZE_WORD);
    rd(0, 32'h1007, HSIZE_BYTE);
    wr(0, 32'h13FC, HSIZE_WORD, 32'hCAFEBABE);
    rd(0, 32'h13FC, HSIZE_WORD);
    run_ops();

    // Slave A: erroneous transfers must not touch the array.
    rd(0, 32'h1002, HSIZE_WORD);
    rd(0, 32'h1400, HSIZE_WORD);
    rd(0, 32'h0FFC, HSIZE_WORD);
    rd(0, 32'h1000, 3'd3);
    wr(0, 32'h1001, HSIZE_HALF, 32'hFFFFFFFF);
    wr(0, 32'h1400, HSIZE_WORD, 32'hFFFFFFFF);
    rd(0, 32'h1000, HSIZE_WORD);
    run_ops();

    // Non-transfers get a zero-wait OKAY with no side effects.
    push_op(0, 1'b1, HTRANS_BUSY,   32'h1000, 1'b1, HSIZE_WORD, 32'h0BAD0BAD);
    push_op(0, 1'b0, HTRANS_NONSEQ, 32'h1000, 1'b1, HSIZE_WORD, 32'h0BAD0BAD);
    push_op(1, 1'b0, HTRANS_NONSEQ, 32'h1004, 1'b0, HSIZE_WORD, 32'h0);
    push_op(0, 1'b1, HTRANS_IDLE,   32'h1000, 1'b0, HSIZE_WORD, 32'h0);
    rd(0, 32'h1000, HSIZE_WORD);
    run_ops();

    // Slave B: zero wait states, back-to-back write then read.
    wr(1, 32'h1004, HSIZE_WORD, 32'h5A5A5A5A);
    rd(1, 32'h1004, HSIZE_WORD);
    rd(1, 32'h1002, HSIZE_WORD);
    wr(1, 32'h1000, HSIZE_WORD, 32'h76543210);
    wr(1, 32'h1001, HSIZE_BYTE, 32'h0000EE00);
    rd(1, 32'h1000, HSIZE_WORD);
    run_ops();

    // Interleaved slaves.
    wr(0, 32'h1010, HSIZE_WORD, 32'hA5A50F0F);
    rd(1, 32'h1004, HSIZE_WORD);
    rd(0, 32'h1010, HSIZE_WORD);
    wr(0, 32'h1008, HSIZE_WORD, 32'h00000000);
    run_ops();

    // Reset during the wait state of a write to 0x1008.
    @(negedge clk);
    hsel_a = 1'b1; haddr = 32'h1008; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    bus_idle();
    hwdata = 32'hCAFEF00D;
    check("wait_before_rst", 32'(hro_a), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(hro_a), 32'h1);
    check("rst_mid_resp", 32'(hresp_a), 32'h0);
    check("rst_mid_rdata", hrd_a, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    hwdata = 32'h0;
    rd(0, 32'h1008, HSIZE_WORD);
    rd(0, 32'h1000, HSIZE_WORD);
    run_ops();

    check("sb_empty", 32'(q_sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the internal array.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, range 0..7, meaning data-phase wait cycles per OKAY transfer.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning byte address of word 0.
REQ-004 Ports SHALL be, one per line:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- hsel  input  1  slave select from decoder.
- haddr  input  32  byte address, address phase.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  input  1  1=write, 0=read.
- hsize  input  3  0=byte, 1=halfword, 2=word.
- hwdata  input  32  write data, data phase.
- hready  input  1  bus-level HREADY from mux.
- hreadyout  output  1  this slave's ready.
- hresp  output  1  0=OKAY, 1=ERROR.
- hrdata  output  32  read data, data phase.

Function
REQ-005 A transfer SHALL be accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1; haddr, hwrite and hsize SHALL be latched on that edge.
REQ-006 IDLE or BUSY transfers, or hsel=0, SHALL receive a zero-wait OKAY: hreadyout=1, hresp=0, no array access.
REQ-007 FSM states SHALL be: ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
REQ-008 On accept, the next state SHALL be:
- ST_ERR1 if the transfer is erroneous (REQ-009).
- ST_DATA if WAIT_STATES=0.
- ST_WAIT otherwise, with the wait counter loaded to WAIT_STATES-1.
REQ-009 A transfer SHALL be erroneous when any of these holds:
- hsize>2.
- Misaligned: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.
- haddr-BASE_ADDR >= DEPTH*4 (unsigned 32-bit compare; addresses below BASE_ADDR wrap and fail).
REQ-010 ST_WAIT SHALL drive hreadyout=0, hresp=0, decrement the counter each cycle, and exit to ST_DATA when the counter is 0.
REQ-011 ST_DATA SHALL drive hreadyout=1, hresp=0.
- Read: hrdata = array[latched word index], combinational from the array.
- Write: commit hwdata to enabled byte lanes on the closing edge.
REQ-012 Byte lanes SHALL be little-endian.
- hsize=0: lane haddr[1:0].
- hsize=1: lanes {haddr[1],0} and {haddr[1],1}.
- hsize=2: all four lanes.
REQ-013 ST_ERR1 SHALL drive hreadyout=0, hresp=1; ST_ERR2 SHALL drive hreadyout=1, hresp=1. An erroneous transfer SHALL NOT modify the array.
REQ-014 In ST_DATA and ST_ERR2, a new transfer SHALL be accepted under REQ-005, giving back-to-back pipelining; otherwise the next state SHALL be ST_IDLE.
REQ-015 Read-after-write to the same word in consecutive transfers SHALL return the newly written data without extra wait.
REQ-016 hrdata SHALL be 32'h0 in every state except ST_DATA on a read.
REQ-017 Total data-phase length SHALL be WAIT_STATES+1 cycles for OKAY transfers and exactly 2 cycles for ERROR.

Reset
REQ-018 Asserting reset low SHALL immediately force state=ST_IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0, and clear all latched address-phase fields.
REQ-019 A write interrupted by reset before its ST_DATA closing edge SHALL NOT modify the array.
REQ-020 Array contents SHALL NOT be cleared by reset.

Structure
REQ-021 Shared package ahb_pkg SHALL hold the HTRANS, HSIZE and HRESP code constants and the slave state enum type.
REQ-022 Byte-lane strobe generation (hsize, addr[1:0] -> 4-bit strobe) SHALL be the sub-module ahb_byte_strobe; the FSM, counter and array stay in ahb_sram_slave.

Verification
REQ-023 With WAIT_STATES=1: NONSEQ word write 0x1000 <- 32'hDEADBEEF, then read 0x1000 -> hreadyout low for 1 cycle each; hrdata=32'hDEADBEEF, hresp=0.
REQ-024 Byte write 0x1002 <- hwdata 32'h00AB0000 over word 32'h11223344, then word read -> 32'h11AB3344.
REQ-025 Word read at 0x1002 (misaligned) and at 0x1400 (out of range) -> cycle 1 hreadyout=0/hresp=1, cycle 2 hreadyout=1/hresp=1, array unchanged.
REQ-026 With WAIT_STATES=0: back-to-back write 0x1004 <- 32'h5A5A5A5A followed directly by read 0x1004 -> hreadyout never low; read returns 32'h5A5A5A5A.
REQ-027 Reset pulsed low during ST_WAIT of a write to 0x1008 (previously 32'h0) -> outputs at reset values immediately; later read of 0x1008 returns 32'h0.
REQ-028 htrans=BUSY with hsel=1, and NONSEQ with hsel=0 -> hreadyout=1, hresp=0, hrdata=0, no state change.
